prefetch_buffer: RTL

- Instruction fetch front end with a prefetch queue. Sits between the instruction memory port and the decode stage.
- Issues in-order, pipelined word requests to instruction memory and buffers the returned words with their PCs.
- Presents one instruction per cycle to decode on the if->id pipeline register.
- On a redirect from decode (jump), flushes the queue and discards stale in-flight responses.

---
 rtl/prefetch_buffer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/prefetch_buffer.sv
// prefetch_buffer: instruction fetch front end with a prefetch queue.
//
// Issues in-order, pipelined word requests to instruction memory. Returned words are
// buffered together with their PCs and presented one per cycle on the if->id register.
// A jump from decode flushes the queue. Responses that are still in flight are dropped
// as they return.
//
// Parameters:
//   DEPTH     queue entries; also the limit on in-flight plus buffered words (power of 2, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   jump, addr         redirect request and target from decode
//   stall              decode cannot accept; hold the if->id register
//   imem_req/addr      request valid and word address to instruction memory
//   imem_ready         memory accepts the request this cycle
//   imem_rvalid/rdata  in-order response word from instruction memory
//   pc_if_id           PC of the instruction presented to decode
//   ir_if_id           instruction presented to decode (0 when bubble)
//   valid_if_id        ir_if_id holds a real instruction
//
// Build option: define PREFETCH_BYPASS_EN to let a response that arrives while the queue
// is empty go straight into the if->id register, which saves one cycle of latency.

module prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump,
    input  logic [31:0] addr,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_if_id,
    output logic [31:0] ir_if_id,
    output logic        valid_if_id
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic             valid_q, valid_d;

    logic [31:0]      buf_pc [DEPTH];
    logic [31:0]      buf_ir [DEPTH];

    logic [SUM_W-1:0] in_use;
    logic             accept;
    logic             resp_keep;
    logic             bypass;
    logic             push;
    logic             pop;

    // Words held in the queue plus words still owed by memory. Capping this at DEPTH
    // guarantees every returning word has a free slot.
    assign in_use    = SUM_W'(count_q) + SUM_W'(outstanding_q);
    assign imem_req  = !rst && !jump && (in_use < SUM_W'(DEPTH));
    assign imem_addr = fetch_pc_q;
    assign accept    = imem_req && imem_ready;

    // A response that arrives in a jump cycle belongs to the old stream.
    assign resp_keep = imem_rvalid && !jump && (discard_q == '0);

`ifdef PREFETCH_BYPASS_EN
    assign bypass = resp_keep && !stall && (count_q == '0);
`else
    assign bypass = 1'b0;
`endif

    assign push = resp_keep && !bypass;
    assign pop  = !jump && !stall && (count_q != '0);

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(imem_rvalid);
        discard_d     = discard_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        valid_d       = valid_q;

        if (jump) begin
            fetch_pc_d = addr;
            resp_pc_d  = addr;
            // Every word still owed is stale. A word that arrives this cycle is already
            // dropped, so it is not counted again.
            discard_d  = outstanding_q - CNT_W'(imem_rvalid);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            ir_d       = '0;
            valid_d    = 1'b0;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (resp_keep) begin
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (imem_rvalid && (discard_q != '0)) begin
                discard_d = discard_q - CNT_W'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);

            if (!stall) begin
                if (bypass) begin
                    pc_d    = resp_pc_q;
                    ir_d    = imem_rdata;
                    valid_d = 1'b1;
                end else if (count_q != '0) begin
                    pc_d    = buf_pc[rd_ptr_q];
                    ir_d    = buf_ir[rd_ptr_q];
                    valid_d = 1'b1;
                end else begin
                    ir_d    = '0;
                    valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            pc_q          <= '0;
            ir_q          <= '0;
            valid_q       <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            valid_q       <= valid_d;
        end
    end

    // Queue storage needs no reset; count_q tracks which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr_q] <= resp_pc_q;
            buf_ir[wr_ptr_q] <= imem_rdata;
        end
    end

    assign pc_if_id    = pc_q;
    assign ir_if_id    = ir_q;
    assign valid_if_id = valid_q;

endmodule
